// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the core's load/store port: holds the core with Stall
// for WAIT_CYCLES+1 cycles, then pulses DataRdy (and BusErr for out-of-range accesses) for one cycle.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        DataWE,
    input  logic [31:0] DataA,
    input  logic [31:0] DataWD,
    output logic [31:0] DataRD,
    output logic        DataRdy,
    output logic        Stall,
    output logic        BusErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_we_q, req_we_d;
    logic [29:0] req_idx_q, req_idx_d;
    logic [31:0] req_wd_q, req_wd_d;
    logic [31:0] rd_q, rd_d;
    logic        rdy_q, berr_q;

    logic [31:0] mem [DEPTH];

    logic        access;
    logic        acc_we;
    logic        acc_inr;
    logic [29:0] acc_idx;
    logic [31:0] acc_wd;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^DataA[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_we_d  = req_we_q;
        req_idx_d = req_idx_q;
        req_wd_d  = req_wd_q;
        access    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReq) begin
                    req_we_d  = DataWE;
                    req_idx_d = DataA[31:2];
                    req_wd_d  = DataWD;
                    cnt_d     = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A zero-wait access fires from IDLE, so it must see the live inputs rather than the latch.
    assign acc_we  = (state_q == ST_IDLE) ? DataWE      : req_we_q;
    assign acc_idx = (state_q == ST_IDLE) ? DataA[31:2] : req_idx_q;
    assign acc_wd  = (state_q == ST_IDLE) ? DataWD      : req_wd_q;
    assign acc_inr = ({2'b00, acc_idx} < 32'(DEPTH));

    always_comb begin
        rd_d = rd_q;
        if (access && !acc_we) begin
            rd_d = acc_inr ? mem[acc_idx[AW-1:0]] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            req_we_q  <= 1'b0;
            req_idx_q <= 30'd0;
            req_wd_q  <= 32'd0;
            rd_q      <= 32'd0;
            rdy_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_we_q  <= req_we_d;
            req_idx_q <= req_idx_d;
            req_wd_q  <= req_wd_d;
            rd_q      <= rd_d;
            rdy_q     <= access;
            berr_q    <= access && !acc_inr;
        end
    end

    // RAM keeps its contents across reset; a store in flight when reset hits is simply lost.
    always_ff @(posedge clk) begin
        if (reset && access && acc_we && acc_inr) begin
            mem[acc_idx[AW-1:0]] <= acc_wd;
        end
    end

    assign DataRD  = rd_q;
    assign DataRdy = rdy_q;
    assign BusErr  = berr_q;
    assign Stall   = reset && MemReq && (state_q != ST_DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a two-wait instance checked every cycle against a
// transaction-level model (word array plus expected output timeline), plus literal spot checks.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        mreq [2];
    logic        dwe  [2];
    logic [31:0] da   [2];
    logic [31:0] dwd  [2];
    logic [31:0] rd   [2];
    logic        rdy  [2];
    logic        stall[2];
    logic        berr [2];

    logic        exp_stall[2];
    logic        exp_rdy  [2];
    logic        exp_berr [2];
    logic [31:0] exp_rd   [2];
    logic [31:0] mmem [2][64];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(rst), .MemReq(mreq[0]), .DataWE(dwe[0]), .DataA(da[0]),
        .DataWD(dwd[0]), .DataRD(rd[0]), .DataRdy(rdy[0]), .Stall(stall[0]), .BusErr(berr[0])
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(rst), .MemReq(mreq[1]), .DataWE(dwe[1]), .DataA(da[1]),
        .DataWD(dwd[1]), .DataRD(rd[1]), .DataRdy(rdy[1]), .Stall(stall[1]), .BusErr(berr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, got, expv, $time);
        end
    endfunction

    // Per-cycle comparison of both instances against the model's expected outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk(d == 0 ? "w0_stall" : "w2_stall", 32'(stall[d]), 32'(exp_stall[d]));
                chk(d == 0 ? "w0_rdy"   : "w2_rdy",   32'(rdy[d]),   32'(exp_rdy[d]));
                chk(d == 0 ? "w0_berr"  : "w2_berr",  32'(berr[d]),  32'(exp_berr[d]));
                chk(d == 0 ? "w0_rd"    : "w2_rd",    rd[d],         exp_rd[d]);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_reset();
        rst    = 1'b0;
        chk_en = 1;
        for (int d = 0; d < 2; d++) begin
            mreq[d]      = 1'b1;
            exp_stall[d] = 1'b0;
            exp_rdy[d]   = 1'b0;
            exp_berr[d]  = 1'b0;
            exp_rd[d]    = 32'd0;
        end
        #1 chk("rst_stall_w2", 32'(stall[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        mreq[0] = 1'b0;
        mreq[1] = 1'b0;
        rst     = 1'b1;
    endtask

    // One access: request visible from cycle N, DONE in cycle N+W+1, returns in the cycle after DONE.
    task automatic access(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input bit keep, input bit scramble,
                          output int sc, output logic rdy_seen, output logic berr_seen);
        int          w;
        logic [29:0] idx;
        w  = (d == 0) ? 0 : 2;
        sc = 0;
        mreq[d] = 1'b1; dwe[d] = we; da[d] = a; dwd[d] = wd;
        exp_stall[d] = 1'b1; exp_rdy[d] = 1'b0; exp_berr[d] = 1'b0;
        #1 if (stall[d]) sc++;
        for (int c = 1; c <= w; c++) begin
            @(posedge clk); #1;
            if (scramble && c == 1) begin
                da[d]  = a ^ 32'h0000_0F00;
                dwd[d] = ~wd;
                dwe[d] = ~we;
            end
            #1 if (stall[d]) sc++;
        end
        @(posedge clk); #1;
        idx = a[31:2];
        if (idx < 30'd64) begin
            if (we) mmem[d][idx[5:0]] = wd;
            else    exp_rd[d] = mmem[d][idx[5:0]];
        end else if (!we) begin
            exp_rd[d] = 32'd0;
        end
        exp_rdy[d]   = 1'b1;
        exp_berr[d]  = (idx >= 30'd64);
        exp_stall[d] = 1'b0;
        if (!keep) mreq[d] = 1'b0;
        #1;
        rdy_seen  = rdy[d];
        berr_seen = berr[d];
        if (stall[d]) sc++;
        @(posedge clk); #1;
        exp_rdy[d]   = 1'b0;
        exp_berr[d]  = 1'b0;
        exp_stall[d] = mreq[d];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, expected completion");
        $fatal(1);
    end

    initial begin
        int   sc;
        logic rs, bs;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mreq[d] = 1'b0; dwe[d] = 1'b0; da[d] = 32'd0; dwd[d] = 32'd0;
            exp_stall[d] = 1'b0; exp_rdy[d] = 1'b0; exp_berr[d] = 1'b0; exp_rd[d] = 32'd0;
        end
        @(posedge clk); #1;
        do_reset();

        // Two-wait instance: store then load, stall length and latency pinned literally.
        access(1, 1'b1, 32'h10, 32'hCAFEF00D, 0, 0, sc, rs, bs);
        chk("st10_stall_cycles", 32'(sc), 32'd3);
        chk("st10_rdy", 32'(rs), 32'd1);
        access(1, 1'b0, 32'h10, 32'h0, 0, 0, sc, rs, bs);
        chk("ld10_rd", rd[1], 32'hCAFEF00D);
        access(1, 1'b0, 32'h13, 32'h0, 0, 0, sc, rs, bs);
        chk("ld13_rd", rd[1], 32'hCAFEF00D);

        // Out of range: must not alias onto word 0 or word 63.
        access(1, 1'b1, 32'hFC, 32'h5A5A0063, 0, 0, sc, rs, bs);
        access(1, 1'b1, 32'h0, 32'h00000777, 0, 0, sc, rs, bs);
        access(1, 1'b1, 32'h100, 32'h11111111, 0, 0, sc, rs, bs);
        chk("st100_berr", 32'(bs), 32'd1);
        access(1, 1'b0, 32'h100, 32'h0, 0, 0, sc, rs, bs);
        chk("ld100_rd", rd[1], 32'h0);
        chk("ld100_berr", 32'(bs), 32'd1);
        access(1, 1'b0, 32'hFC, 32'h0, 0, 0, sc, rs, bs);
        chk("ldfc_rd", rd[1], 32'h5A5A0063);
        chk("ldfc_berr", 32'(bs), 32'd0);
        access(1, 1'b0, 32'h0, 32'h0, 0, 0, sc, rs, bs);
        chk("ld0_rd", rd[1], 32'h00000777);

        // Inputs scrambled during WAIT must not affect the latched request.
        access(1, 1'b1, 32'h40, 32'hDEADBEEF, 0, 1, sc, rs, bs);
        access(1, 1'b0, 32'h40, 32'h0, 0, 0, sc, rs, bs);
        chk("ld40_rd", rd[1], 32'hDEADBEEF);

        // Reset in the middle of a store's WAIT leaves memory untouched.
        access(1, 1'b1, 32'h20, 32'h12345678, 0, 0, sc, rs, bs);
        mreq[1] = 1'b1; dwe[1] = 1'b1; da[1] = 32'h20; dwd[1] = 32'hAAAA5555;
        exp_stall[1] = 1'b1;
        @(posedge clk); #1;
        do_reset();
        chk("post_rst_rd", rd[1], 32'h0);
        access(1, 1'b0, 32'h20, 32'h0, 0, 0, sc, rs, bs);
        chk("ld20_rd", rd[1], 32'h12345678);

        // Back-to-back on the two-wait instance: request held through DONE, accepted in the bubble.
        access(1, 1'b0, 32'h10, 32'h0, 1, 0, sc, rs, bs);
        access(1, 1'b0, 32'hFC, 32'h0, 0, 0, sc, rs, bs);
        chk("b2b_w2_rd", rd[1], 32'h5A5A0063);

        // Zero-wait instance: DataRdy one cycle after acceptance, back-to-back loads.
        access(0, 1'b1, 32'h8, 32'h0BADF00D, 0, 0, sc, rs, bs);
        chk("w0_st_stall_cycles", 32'(sc), 32'd1);
        chk("w0_st_rdy", 32'(rs), 32'd1);
        access(0, 1'b1, 32'h4, 32'h00C0FFEE, 0, 0, sc, rs, bs);
        access(0, 1'b0, 32'h8, 32'h0, 1, 0, sc, rs, bs);
        chk("w0_ld8_rd", rd[0], 32'h0BADF00D);
        chk("w0_bubble_stall", 32'(stall[0]), 32'd1);
        access(0, 1'b0, 32'h4, 32'h0, 0, 0, sc, rs, bs);
        chk("w0_ld4_rd", rd[0], 32'h00C0FFEE);
        chk("w0_ld4_stall_cycles", 32'(sc), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
